// File: rtl/coincidence_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | coincidence_unit: store digit/minor timing and addressed-word gating.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module coincidence_unit #(
    parameter int DIGITS_MINOR = 36,
    parameter int MINORS       = 16,
    parameter int TANKS        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             abort,
    input  logic             f1_pos,
    input  logic             f2_pos,
    input  logic [3:0]       pos,
    input  logic [4:0]       tank,
    output logic [5:0]       digit_cnt,
    output logic [3:0]       minor_cnt,
    output logic [TANKS-1:0] tank_sel,
    output logic             gate,
    output logic [5:0]       word_digit,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_GATE = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [5:0] c_DIGIT_LAST = 6'(DIGITS_MINOR - 1);
    localparam logic [3:0] c_MINOR_LAST = 4'(MINORS - 1);
    localparam logic [5:0] c_HALF       = 6'(DIGITS_MINOR / 2);
    // Final word_digit of a window: long words stop short of the sandwich digit.
    localparam logic [5:0] c_LONG_LAST  = 6'(DIGITS_MINOR - 2);
    localparam logic [5:0] c_SHORT_LAST = 6'(DIGITS_MINOR / 2 - 2);

    logic [1:0]       r_state;
    logic [5:0]       r_digit;
    logic [3:0]       r_minor;
    logic [3:0]       r_pos;
    logic             r_long;
    logic             r_half;
    logic [5:0]       r_word_digit;
    logic [TANKS-1:0] r_tank_sel;

    logic [5:0]       w_start_digit;
    logic [5:0]       w_last;
    logic             w_match;
    logic [TANKS-1:0] w_onehot;

    assign w_start_digit = (!r_long && r_half) ? c_HALF : 6'd0;
    assign w_last        = r_long ? c_LONG_LAST : c_SHORT_LAST;
    assign w_match       = (r_minor == r_pos) && (r_digit == w_start_digit);
    assign w_onehot      = {{(TANKS-1){1'b0}}, 1'b1} << tank;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit <= 6'd0;
            r_minor <= 4'd0;
        end else if (r_digit == c_DIGIT_LAST) begin
            r_digit <= 6'd0;
            r_minor <= (r_minor == c_MINOR_LAST) ? 4'd0 : r_minor + 4'd1;
        end else begin
            r_digit <= r_digit + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_pos        <= 4'd0;
            r_long       <= 1'b0;
            r_half       <= 1'b0;
            r_word_digit <= 6'd0;
            r_tank_sel   <= '0;
        end else if (abort) begin
            r_state      <= c_IDLE;
            r_word_digit <= 6'd0;
            r_tank_sel   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req) begin
                        r_pos      <= pos;
                        r_long     <= f1_pos;
                        r_half     <= f2_pos;
                        r_tank_sel <= w_onehot;
                        r_state    <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    // The matching cycle itself is word digit 0.
                    if (w_match) begin
                        r_word_digit <= 6'd1;
                        r_state      <= c_GATE;
                    end
                end
                c_GATE: begin
                    if (r_word_digit == w_last) begin
                        r_word_digit <= 6'd0;
                        r_state      <= c_DONE;
                    end else begin
                        r_word_digit <= r_word_digit + 6'd1;
                    end
                end
                c_DONE: begin
                    r_tank_sel <= '0;
                    r_state    <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign digit_cnt  = r_digit;
    assign minor_cnt  = r_minor;
    assign tank_sel   = r_tank_sel;
    assign word_digit = r_word_digit;
    assign gate       = (r_state == c_GATE) || ((r_state == c_WAIT) && w_match);
    assign busy       = (r_state == c_WAIT) || (r_state == c_GATE);
    assign done       = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_coincidence_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_coincidence_unit: scoreboard bench with an absolute-time window model.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_coincidence_unit;

    localparam int DIG = 36;
    localparam int MIN = 16;
    localparam int NT  = 32;
    localparam int MAJ = DIG * MIN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          abort = 1'b0;
    logic          f1_pos = 1'b0;
    logic          f2_pos = 1'b0;
    logic [3:0]    pos = 4'd0;
    logic [4:0]    tank = 5'd0;
    logic [5:0]    digit_cnt;
    logic [3:0]    minor_cnt;
    logic [NT-1:0] tank_sel;
    logic          gate;
    logic [5:0]    word_digit;
    logic          busy;
    logic          done;

    coincidence_unit #(.DIGITS_MINOR(DIG), .MINORS(MIN), .TANKS(NT)) dut (
        .clk(clk), .rst(rst), .req(req), .abort(abort),
        .f1_pos(f1_pos), .f2_pos(f2_pos), .pos(pos), .tank(tank),
        .digit_cnt(digit_cnt), .minor_cnt(minor_cnt), .tank_sel(tank_sel),
        .gate(gate), .word_digit(word_digit), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Cycles since reset: the store counters are simply this value modulo the cycle lengths.
    int cyc;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int c;
        bit is_done;
        int wd;
        int tk;
    } ev_t;

    ev_t q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    bit  rec_valid = 1'b0;
    int  rec_tank, sel_lo, sel_hi, busy_lo, busy_hi;
    int  idle_from = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    logic [63:0] exp_sel;
    logic        exp_busy;
    ev_t         e;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_sel  = 64'd0;
                exp_busy = 1'b0;
                if (rec_valid && cyc >= sel_lo && cyc <= sel_hi) exp_sel = 64'd1 << rec_tank;
                if (rec_valid && cyc >= busy_lo && cyc <= busy_hi) exp_busy = 1'b1;
                check("digit_cnt", 64'(digit_cnt), 64'(cyc % DIG));
                check("minor_cnt", 64'(minor_cnt), 64'((cyc / DIG) % MIN));
                check("tank_sel", 64'(tank_sel), exp_sel);
                check("busy", 64'(busy), 64'(exp_busy));
                while (q.size() > 0 && q[0].c < cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL missed_event: expected %s at cyc %0d, did not occur (now %0d)",
                             q[0].is_done ? "done" : "gate", q[0].c, cyc);
                    void'(q.pop_front());
                end
                if (gate || done) begin
                    if (q.size() == 0) begin
                        check("unexpected_output", 64'({gate, done}), 64'd0);
                    end else begin
                        e = q.pop_front();
                        check("event_cycle", 64'(cyc), 64'(e.c));
                        check("gate", 64'(gate), 64'(!e.is_done));
                        check("done", 64'(done), 64'(e.is_done));
                        if (!e.is_done) check("word_digit", 64'(word_digit), 64'(e.wd));
                    end
                end
                if (cyc == 0) begin
                    check("reset_gate", 64'(gate), 64'd0);
                    check("reset_done", 64'(done), 64'd0);
                    check("reset_word_digit", 64'(word_digit), 64'd0);
                end
            end
        end
    end

    // Drive one cycle's inputs and advance the reference model for that cycle.
    task automatic apply(bit r, bit a, bit f1, bit f2, int p, int tk, bit do_rst);
        int ds, len, cur, tgt, start;
        req = r; abort = a; f1_pos = f1; f2_pos = f2;
        pos = p[3:0]; tank = tk[4:0]; rst = do_rst;
        if (do_rst) begin
            rec_valid = 1'b0;
            q.delete();
            idle_from = 0;
        end else if (a) begin
            q.delete();
            if (sel_hi > cyc)  sel_hi = cyc;
            if (busy_hi > cyc) busy_hi = cyc;
            if (idle_from > cyc + 1) idle_from = cyc + 1;
        end else if (r && cyc >= idle_from) begin
            ds    = f1 ? 0 : (f2 ? DIG / 2 : 0);
            len   = f1 ? DIG - 1 : DIG / 2 - 1;
            cur   = (cyc + 1) % MAJ;
            tgt   = (p % MIN) * DIG + ds;
            start = cyc + 1 + ((tgt - cur + MAJ) % MAJ);
            rec_valid = 1'b1;
            rec_tank  = tk % NT;
            sel_lo    = cyc + 1;
            sel_hi    = start + len;
            busy_lo   = cyc + 1;
            busy_hi   = start + len - 1;
            idle_from = start + len + 1;
            for (int k = 0; k < len; k++) q.push_back('{start + k, 1'b0, k, tk % NT});
            q.push_back('{start + len, 1'b1, 0, tk % NT});
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
        apply(1'b0, 1'b0, 1'($urandom % 2), 1'($urandom % 2),
              int'($urandom % 16), int'($urandom % 32), 1'b0);
    endtask

    task automatic tick_req(bit f1, bit f2, int p, int tk);
        @(negedge clk); #1;
        apply(1'b1, 1'b0, f1, f2, p, tk, 1'b0);
    endtask

    task automatic wait_slot(int m, int d);
        for (int i = 0; i < MAJ + 1; i++) begin
            if ((cyc + 1) % MAJ == m * DIG + d) break;
            tick();
        end
    endtask

    task automatic run_until(int c);
        for (int i = 0; i < 2 * MAJ; i++) begin
            if (cyc + 1 >= c) break;
            tick();
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2 * MAJ; i++) begin
            if (cyc + 1 >= idle_from) break;
            tick();
        end
        tick();
    endtask

    int s;

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk); #1;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (600) tick();

        // Long word, tank 0x13, requested from minor cycle 2.
        wait_slot(2, 0);
        tick_req(1'b1, 1'b0, 5, 19);
        wait_idle();

        // Upper short-word slot in the last minor cycle.
        wait_slot(9, 7);
        tick_req(1'b0, 1'b1, 15, int'($urandom % 32));
        wait_idle();

        // Lower short-word slot.
        tick_req(1'b0, 1'b0, 11, 0);
        wait_idle();

        // Window opens the cycle right after the request.
        wait_slot(3, 35);
        tick_req(1'b1, 1'b0, 4, 7);
        wait_idle();

        // Window start just passed: a full major cycle of waiting.
        wait_slot(4, 0);
        tick_req(1'b1, 1'b0, 4, 21);
        wait_idle();

        // Abort partway through the word.
        wait_slot(6, 0);
        tick_req(1'b1, 1'b0, 7, 3);
        s = q[0].c;
        run_until(s + 10);
        @(negedge clk); #1;
        apply(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (5) tick();

        // A second request during the window must be ignored.
        tick_req(1'b0, 1'b0, 9, 12);
        s = q[0].c;
        run_until(s + 5);
        tick_req(1'b1, 1'b0, 1, 9);
        wait_idle();

        // Abort and request together: request dropped.
        @(negedge clk); #1;
        apply(1'b1, 1'b1, 1'b1, 1'b0, (cyc / DIG + 1) % MIN, 5, 1'b0);
        repeat (40) tick();

        // Request in the DONE cycle is ignored.
        tick_req(1'b1, 1'b0, 2, 4);
        run_until(idle_from - 1);
        tick_req(1'b1, 1'b0, (cyc / DIG + 1) % MIN, 8);
        wait_idle();

        // Random traffic, including requests while busy and stray aborts.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            apply(1'($urandom % 60 == 0), 1'($urandom % 300 == 0),
                  1'($urandom % 2), 1'($urandom % 2),
                  int'($urandom % 16), int'($urandom % 32), 1'b0);
        end
        wait_idle();

        // Reset in the middle of an operation.
        tick_req(1'b1, 1'b0, int'($urandom % 16), int'($urandom % 32));
        repeat (20) tick();
        @(negedge clk); #1;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        @(negedge clk); #1;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        @(negedge clk); #1;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (40) tick();
        tick_req(1'b0, 1'b0, 1, 2);
        wait_idle();

        check("queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coincidence_unit.md
Name: coincidence_unit

Overview:
- Companion to the tank number flashing stage in main control. The flashing flipflops choose which tank is routed; this block chooses the word position inside that tank.
- It runs the free-running digit/minor-cycle timing of the store and latches the word position and tank number.
- It opens a transfer gate exactly over the digit times of the addressed word, then reports completion.
- It also drives the registered one-hot tank select consumed by the tank read/write gating.

Parameters:
- DIGITS_MINOR, 36, digit times per minor cycle: one long word, or two 18-digit short-word slots.
- MINORS, 16, minor cycles per major cycle (long-word positions per tank).
- TANKS, 32, number of tanks addressed by the 5-bit tank number.

Ports:
- clk  input  1  digit-time clock.
- rst  input  1  synchronous, active-high reset.
- req  input  1  single-cycle strobe; start a coincidence search for the address presently on the f inputs.
- abort  input  1  synchronous cancel, driven from EPSEP or end-of-stage logic.
- f1_pos  input  1  1 = long word (35 digits), 0 = short word (17 digits).
- f2_pos  input  1  short-word half select: 0 = digits 0-16, 1 = digits 18-34. Ignored for long words.
- pos  input  4  minor-cycle (long-word) position within the tank, from f3..f6.
- tank  input  5  tank number {f11,f10,f9,f8,f7}.
- digit_cnt  output  6  free-running digit counter, 0..DIGITS_MINOR-1.
- minor_cnt  output  4  free-running minor-cycle counter, 0..MINORS-1.
- tank_sel  output  TANKS  registered one-hot tank select.
- gate  output  1  transfer window for the addressed word.
- word_digit  output  6  index of the current digit within the word, LSB first; valid while gate=1.
- busy  output  1  high in WAIT or GATE.
- done  output  1  one-cycle pulse after the last gated digit.

Behaviour:
- Reset values: digit_cnt=0, minor_cnt=0, tank_sel=0, gate=0, word_digit=0, busy=0, done=0, state=IDLE.

Timing counters:
- digit_cnt increments every cycle and wraps DIGITS_MINOR-1 -> 0.
- On that wrap, minor_cnt increments and wraps MINORS-1 -> 0. A major cycle is 576 clocks.
- The counters never stop for req or abort; only rst clears them.

Window start (m_s, d_s) and length L:
- Long word: m_s = pos, d_s = 0, L = 35.
- Short word: m_s = pos, d_s = 18*f2_pos, L = 17.

States: IDLE, WAIT, GATE, DONE.
- IDLE, req=1: latch pos, f1_pos, f2_pos and tank. tank_sel <= one-hot(tank) in the next cycle. Go to WAIT.
- WAIT: if (minor_cnt, digit_cnt) == (m_s, d_s), gate=1 this cycle, word_digit=0, go to GATE. Otherwise stay in WAIT.
- GATE: gate=1 and word_digit increments each cycle. When word_digit reaches L-1, go to DONE.
- DONE: done=1, gate=0, tank_sel <= 0. Go to IDLE.

Gate signal:
- gate is decoded from registered state and counters only. It must be glitch-free and combinationally independent of req, f*, pos and tank.

Latency:
- The earliest gate is the cycle after req.
- The worst case is 576 cycles after req, when the window start has just passed.
- A window that starts one cycle after req must not be missed.

Boundary conditions:
- req while busy or in DONE: ignored. Latched values are unchanged.
- Changes on the f*/pos/tank inputs after req: no effect until the next accepted req.
- abort in any state: next cycle state=IDLE, gate=0, tank_sel=0, done is not pulsed.
- abort and req in the same cycle: abort wins and the request is dropped.
- rst mid-operation: everything returns to reset values, including the counters.
- Long words span the full minor cycle: digit 35 (the sandwich digit) is never gated.
- Short word with f2_pos=1 ends at digit 34.
- A window never crosses a minor-cycle boundary.
- tank_sel is always one-hot or all-zero, never multi-hot.

Test Plan:
- Reset, then run 600 clocks with no req -> digit_cnt wraps 35->0 every 36 clocks; minor_cnt wraps 15->0 at clock 576; all other outputs stay 0.
- req with f1=1, pos=5, tank=0x13 issued when minor_cnt=2 -> tank_sel=1<<19 next cycle; gate high for exactly 35 cycles starting at (minor 5, digit 0); word_digit runs 0..34; done pulses once at (5,35); tank_sel returns to 0.
- Short word: f1=0, f2=1, pos=15 -> gate spans (15,18)..(15,34), 17 cycles; digits 0-17 and 35 are never gated.
- Immediate-start case: req issued at (3,35) with f1=1, pos=4 -> gate asserts on the very next cycle (4,0).
- Missed-window case: req at (4,0) with pos=4, f1=1 -> gate starts 576 cycles later.
- Abort and illegal req: abort at word_digit=10 -> gate drops, no done, tank_sel=0. Separately, a second req issued during GATE -> ignored, and the original window completes unchanged.
